serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial adder that drives one combinational `fulladder` cell with an operand shift datapath and a registered carry, adding two WIDTH-bit words LSB-first at one bit per clock. It is the sequential consumer of the `fulladder` cell's `s`/`cout`. It trades WIDTH cycles of latency for a single adder cell. It sits between an operand source that pulses `start` and any sink that samples `sum`/`cout` on `done`.

## Interface
- `WIDTH`, default 8: operand width in bits, must be ≥ 2.
- `clk`  in  1: single clock, rising-edge.
- `reset`  in  1: synchronous, active-high; all state cleared at the edge where it is sampled high.
- `start`  in  1: request. Sampled only in IDLE or DONE; ignored in RUN.
- `a`  in  WIDTH: operand A, captured at the accepting edge.
- `b`  in  WIDTH: operand B, captured at the accepting edge.
- `cin`  in  1: carry-in, captured at the accepting edge.
- `busy`  out  1: high while in RUN.
- `done`  out  1: one-cycle pulse; `sum`/`cout` are valid.
- `sum`  out  WIDTH: result register.
- `cout`  out  1: final carry register.

## Operation
- FSM states are IDLE, RUN and DONE. Reset state is IDLE.
- IDLE, `start`=1: load `a_sr`←`a`, `b_sr`←`b`, `carry`←`cin`, `cnt`←0, then go to RUN.
- RUN, each edge:
  - The `fulladder` inputs are `a_sr[0]`, `b_sr[0]` and `carry`.
  - `s_sr` shifts right with the cell's `s` entering at the MSB. `a_sr` and `b_sr` shift right.
  - `carry`←cell `cout`, and `cnt`←`cnt`+1.
- RUN with `cnt`=WIDTH-1: perform the final shift. Load `sum`←{s, `s_sr`[WIDTH-1:1]} and `cout`←cell `cout`, then go to DONE.
- DONE: `done`=1 for exactly one cycle.
  - `start`=1 at this edge: accept new operands as in IDLE and go to RUN (back-to-back).
  - Otherwise: go to IDLE.
- `sum` and `cout` hold their values until the next completion. They are not cleared by a new `start`.
- Arithmetic is unsigned: {`cout`,`sum`} = `a` + `b` + `cin` modulo 2^(WIDTH+1). There is no overflow flag.
- `cnt` is `$clog2(WIDTH)` bits wide and never wraps past WIDTH-1.
- Reset mid-operation: abort the addition and return to IDLE. `busy`, `done`, `sum` and `cout` are 0 at the following cycle.

## Timing
- Reset values: `busy`=0, `done`=0, `sum`=0, `cout`=0. All internal registers are 0.
- All outputs are registered. There is no combinational path from any input to any output.
- Start accepted at edge E0: `busy`=1 after E0 through edge E(WIDTH).
- Bits are processed at edges E1..E(WIDTH).
- `done`=1 for the cycle after E(WIDTH). Latency from the accepting edge to `done` is WIDTH edges.
- Throughput is one addition per WIDTH+1 cycles with back-to-back starts.
- `start` held high continuously re-triggers at every DONE.
- `start` during RUN is dropped. It is not queued.
- Simultaneous `reset` and `start`: reset wins and the request is lost.

## Structure
- Shared package `serial_adder_pkg` holds:
  - state encoding localparams: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - the default width constant, `SA_WIDTH_DEFAULT`=8.
- Sub-module: exactly one instance of the existing `fulladder` (ports a, b, cin, s, cout) for the per-bit add.
- No other hierarchy. Implement the FSM, counter and shift registers in the top.

## Test plan
All scenarios use WIDTH=8.
- Zero case: a=8'h00, b=8'h00, cin=0, start pulse.
  - `done` appears 8 edges after acceptance with `sum`=8'h00, `cout`=0.
  - `busy` is high for exactly 8 cycles.
- Full carry chain: a=8'hFF, b=8'h01, cin=0 → `sum`=8'h00, `cout`=1.
- Carry-in: a=8'hA5, b=8'h5A, cin=1 → `sum`=8'h00, `cout`=1. A second case, a=8'h7F, b=8'h01, cin=0 → `sum`=8'h80, `cout`=0.
- Ignored start: start a=8'h03, b=8'h04, then pulse `start` with a=8'hFF, b=8'hFF at the 3rd RUN cycle.
  - Result is `sum`=8'h07, `cout`=0, with a single `done` pulse.
- Back-to-back: hold `start` high with a=8'h10, b=8'h20, then a=8'h01, b=8'h01 presented at the first DONE cycle.
  - Two `done` pulses 9 cycles apart, giving 8'h30 then 8'h02.
  - `busy` is low only during the DONE cycles.
- Reset mid-op: assert `reset` for one cycle at the 5th RUN cycle of a=8'hFF, b=8'hFF.
  - Next cycle: `busy`=0, `done`=0, `sum`=0, `cout`=0.
  - No `done` pulse is seen until a fresh `start`.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state encoding and width default for serial_adder
// Purpose: FSM state codes and default operand width used by the interface and top.
// Ports: none (package).
package serial_adder_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int SA_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        S_IDLE = IDLE,
        S_RUN  = RUN,
        S_DONE = DONE
    } sa_state_t;

endpackage

// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - request/result bundle between operand source, serial_adder and result sink
// Purpose: groups the start request, operands and registered results.
// Ports: master drives start/a/b/cin and observes busy/done/sum/cout; slave is the adder side.
interface serial_adder_if
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH_DEFAULT
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/fulladder.sv
// rtl/fulladder.sv - single-bit combinational full adder cell
// Purpose: one-bit sum and carry of a + b + cin.
// Ports: a, b, cin in; s (sum bit), cout (carry out) out.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder, one fulladder cell, LSB first, one bit per clock
// Purpose: computes {cout,sum} = a + b + cin over WIDTH cycles.
// Ports: clk (rising edge), reset (sync, active high), bus (serial_adder_if.slave:
//        start/a/b/cin request, busy/done/sum/cout registered results).
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    serial_adder_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    sa_state_t        state_q, state_d;
    logic [WIDTH-1:0] a_sr, b_sr, s_sr;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             accept;
    logic             last_bit;
    logic             fa_s, fa_cout;

    fulladder u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_cout)
    );

    assign last_bit = (cnt == CNT_LAST);

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: begin
                accept = bus.start;
                if (bus.start) state_d = S_RUN;
            end
            S_RUN: begin
                // start is deliberately not looked at here: requests during RUN are dropped
                if (last_bit) state_d = S_DONE;
            end
            S_DONE: begin
                accept  = bus.start;
                state_d = bus.start ? S_RUN : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            a_sr    <= '0;
            b_sr    <= '0;
            s_sr    <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_sr  <= bus.a;
                b_sr  <= bus.b;
                carry <= bus.cin;
                cnt   <= '0;
            end else if (state_q == S_RUN) begin
                a_sr  <= a_sr >> 1;
                b_sr  <= b_sr >> 1;
                s_sr  <= {fa_s, s_sr[WIDTH-1:1]};
                carry <= fa_cout;
                if (last_bit) begin
                    // final bit goes straight into the result; cnt holds at WIDTH-1
                    sum_q  <= {fa_s, s_sr[WIDTH-1:1]};
                    cout_q <= fa_cout;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    assign bus.busy = (state_q == S_RUN);
    assign bus.done = (state_q == S_DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - scoreboard bench for serial_adder with directed vectors
module tb_serial_adder;
    import serial_adder_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(W)) bus ();

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int cyc      = 0;
    int n_chk    = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    int busy_cnt = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        else
            n_pass++;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops an expectation on every done pulse
    always @(negedge clk) begin
        if (bus.busy) busy_cnt <= busy_cnt + 1;
        if (bus.done) begin
            done_cnt <= done_cnt + 1;
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("sum", 32'(bus.sum), 32'(e.sum));
                check("cout", 32'(bus.cout), 32'(e.cout));
                check("done_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Presents a request for one edge; the accepting edge is the next one,
    // and done is expected in the cycle WIDTH edges later.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                            input logic [W-1:0] s, input logic co, input bit track);
        exp_t x;
        bus.a     = a;
        bus.b     = b;
        bus.cin   = ci;
        bus.start = 1'b1;
        if (track) begin
            x.sum  = s;
            x.cout = co;
            x.cyc  = cyc + 1 + W;
            sb.push_back(x);
        end
        tick(1);
        bus.start = 1'b0;
    endtask

    int b0, d0;

    initial begin
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
        tick(2);
        reset = 1'b0;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_sum", 32'(bus.sum), 32'd0);
        check("rst_cout", 32'(bus.cout), 32'd0);
        tick(1);

        // zero case, with busy length
        b0 = busy_cnt;
        start_op(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
        tick(10);
        check("zero_busy_cycles", 32'(busy_cnt - b0), 32'd8);

        start_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1);
        tick(10);
        start_op(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b1);
        tick(10);
        start_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        tick(10);

        // start pulsed in the 3rd RUN cycle must be dropped
        d0 = done_cnt;
        start_op(8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b1);
        tick(2);
        bus.a     = 8'hFF;
        bus.b     = 8'hFF;
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        tick(10);
        check("ignored_start_done_pulses", 32'(done_cnt - d0), 32'd1);

        // back-to-back with start held through the first DONE
        d0 = done_cnt;
        b0 = busy_cnt;
        bus.a     = 8'h10;
        bus.b     = 8'h20;
        bus.cin   = 1'b0;
        bus.start = 1'b1;
        e.sum = 8'h30; e.cout = 1'b0; e.cyc = cyc + 1 + W;
        sb.push_back(e);
        e.sum = 8'h02; e.cout = 1'b0; e.cyc = cyc + 1 + W + W + 1;
        sb.push_back(e);
        tick(W + 1);
        bus.a = 8'h01;
        bus.b = 8'h01;
        tick(1);
        bus.start = 1'b0;
        tick(12);
        check("b2b_done_pulses", 32'(done_cnt - d0), 32'd2);
        check("b2b_busy_cycles", 32'(busy_cnt - b0), 32'd16);

        // reset during the 5th RUN cycle
        d0 = done_cnt;
        start_op(8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0);
        tick(4);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        check("midrst_sum", 32'(bus.sum), 32'd0);
        check("midrst_cout", 32'(bus.cout), 32'd0);
        tick(15);
        check("midrst_no_done", 32'(done_cnt - d0), 32'd0);

        // fresh start after the abort
        start_op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b1);
        tick(10);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
